serial_crc_engine: RTL and testbench
====================================

# serial_crc_engine

Parametrised bit-serial CRC generator: accepts DATA_W-bit words over a valid/ready handshake, shifts one bit per clock through a configurable CRC_W-bit LFSR, and presents the final CRC with a one-cycle valid strobe at end of frame. Generalises the fixed 16-bit/8-bit serial CRC to any polynomial, width, init value, output XOR and bit order, with multi-word frames, back-pressure and synchronous abort. Sits between a byte/word source (packet framer, UART RX) and the checker/appender that consumes the CRC.

## Interface
- CRC_W, 16, CRC register width (1..64)
- DATA_W, 8, input word width (>=1)
- POLY, 16'h1021, generator polynomial in normal (MSB-first) form, implicit x^CRC_W term omitted
- INIT, 0, register value loaded at start of each frame
- XOR_OUT, 0, value XORed onto the register to form o_crc
- REFLECT, 0, 0 = MSB-first (left shift, POLY); 1 = LSB-first (right shift, bit-reversed POLY)

- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_clear  in  1  synchronous frame abort
- i_data  in  DATA_W  input word
- i_valid  in  1  i_data/i_last valid
- i_last  in  1  word is final word of frame
- o_ready  out  1  engine can accept a word this cycle
- o_busy  out  1  frame in progress (first word accepted, DONE not yet left)
- o_crc  out  CRC_W  register ^ XOR_OUT
- o_crc_valid  out  1  one-cycle strobe, o_crc is the final frame CRC

## Operation
- States: IDLE, SHIFT, DONE. Bit counter cnt (0..DATA_W-1), word register, last flag, frame_active flag.
- IDLE: o_ready=1. On i_valid&o_ready: capture i_data, i_last; if frame_active=0 load crc<=INIT and set frame_active; cnt<=0; go SHIFT. i_valid without handshake has no effect.
- SHIFT: o_ready=0. One bit per cycle. REFLECT=0: bit order DATA_W-1 down to 0; fb=crc[CRC_W-1]^bit; crc<=(crc<<1)^(fb?POLY:0). REFLECT=1: bit order 0 up to DATA_W-1; fb=crc[0]^bit; crc<=(crc>>1)^(fb?rev(POLY):0). Arithmetic modulo 2, truncated to CRC_W. On cnt=DATA_W-1: last flag set -> DONE, else -> IDLE.
- DONE: o_crc_valid=1 for exactly this cycle; frame_active<=0; next state IDLE. o_crc holds the final value until the next frame's first word is accepted.
- REFLECT=1 output is not re-reflected (register already holds refout=true form).
- o_crc is combinational from the register; during SHIFT it shows intermediate values and is not qualified.
- i_clear (any state): next state IDLE, crc<=INIT, frame_active<=0, no o_crc_valid; takes priority over a simultaneous handshake (word discarded).
- Reset priority: i_rst_n=0 overrides i_clear and handshake.

## Timing
- After a reset edge: state IDLE, o_ready=1, o_busy=0, o_crc_valid=0, o_crc=INIT^XOR_OUT, cnt=0.
- Per word: accept edge + DATA_W shift edges; o_ready returns high the cycle after the last shift edge -> max throughput one word per DATA_W+1 cycles.
- Last word accepted at edge E: o_crc_valid high in the cycle after edge E+DATA_W; IDLE (o_ready=1) after edge E+DATA_W+1.
- Frame of N words, no gaps: N*(DATA_W+1)+1 cycles from first accept to return to IDLE.
- Idle gaps between words of a frame do not alter the result.
- Reset or i_clear mid-SHIFT: partial word and frame discarded; next accepted word starts a fresh frame from INIT.
- Single-word frame (i_last on first word) valid; back-to-back frames start on the IDLE cycle after DONE.

## Test plan
- XMODEM (POLY 16'h1021, INIT 0, XOR_OUT 0, REFLECT 0): ASCII "123456789", i_last on '9', no gaps -> o_crc=16'h31C3, o_crc_valid high one cycle, 9*9+1 cycles total.
- CCITT-FALSE (INIT 16'hFFFF) same stimulus -> 16'h29B1; KERMIT (INIT 0, REFLECT 1) -> 16'h2189; CRC-32 (CRC_W 32, POLY 32'h04C11DB7, INIT/XOR_OUT 32'hFFFFFFFF, REFLECT 1) -> 32'hCBF43926.
- Back-pressure: XMODEM "123456789", i_valid held high with i_data changed to 8'hFF during SHIFT cycles and random idle gaps between words -> still 16'h31C3; o_ready low exactly DATA_W cycles per word.
- Abort: XMODEM, send "1234", assert i_clear with i_valid high in IDLE -> no handshake, no o_crc_valid, o_crc=16'h0000; then "123456789" -> 16'h31C3. Repeat with i_rst_n low mid-SHIFT -> same results, o_ready=1 after reset edge.
- Back-to-back frames: XMODEM single word 8'h00 with i_last -> 16'h0000 strobe; immediately "123456789" -> 16'h31C3; CCITT-FALSE second frame confirms INIT 16'hFFFF reloaded (16'h29B1).

Source files
------------

// File: rtl/serial_crc_engine.sv
// Bit-serial CRC engine: one input bit per clock through a parametrised LFSR,
// multi-word frames over valid/ready, final CRC flagged by a one-cycle strobe.
module serial_crc_engine #(
    parameter int unsigned      CRC_W   = 16,
    parameter int unsigned      DATA_W  = 8,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(16'h1021),
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter bit               REFLECT = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_busy,
    output logic [CRC_W-1:0]  o_crc,
    output logic              o_crc_valid
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // LSB-first operation needs the polynomial with its bit order reversed
    function automatic logic [CRC_W-1:0] rev_bits(input logic [CRC_W-1:0] p);
        logic [CRC_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CRC_W); i++) begin
            r[i] = p[int'(CRC_W) - 1 - i];
        end
        return r;
    endfunction

    localparam logic [CRC_W-1:0] POLY_R = rev_bits(POLY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic [CRC_W-1:0]   r_crc;
    logic [DATA_W-1:0]  r_word;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last;
    logic               r_frame_active;
    logic               r_ready;
    logic               r_crc_valid;

    logic               w_bit;
    logic               w_fb;
    logic [CRC_W-1:0]   w_crc_next;
    logic [DATA_W-1:0]  w_word_next;

    // The word register shifts so the next serial bit always sits at a fixed end
    assign w_bit       = REFLECT ? r_word[0] : r_word[DATA_W-1];
    assign w_word_next = REFLECT ? (r_word >> 1) : (r_word << 1);
    assign w_fb        = w_bit ^ (REFLECT ? r_crc[0] : r_crc[CRC_W-1]);
    assign w_crc_next  = REFLECT ? ((r_crc >> 1) ^ (w_fb ? POLY_R : '0))
                                 : ((r_crc << 1) ^ (w_fb ? POLY   : '0));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_crc          <= INIT;
            r_word         <= '0;
            r_cnt          <= '0;
            r_last         <= 1'b0;
            r_frame_active <= 1'b0;
            r_ready        <= 1'b1;
            r_crc_valid    <= 1'b0;
        end else if (i_clear) begin
            r_state        <= ST_IDLE;
            r_crc          <= INIT;
            r_cnt          <= '0;
            r_frame_active <= 1'b0;
            r_ready        <= 1'b1;
            r_crc_valid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_word  <= i_data;
                        r_last  <= i_last;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= ST_SHIFT;
                        if (!r_frame_active) begin
                            r_crc          <= INIT;
                            r_frame_active <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_crc  <= w_crc_next;
                    r_word <= w_word_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        if (r_last) begin
                            r_state     <= ST_DONE;
                            r_crc_valid <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_crc_valid    <= 1'b0;
                    r_frame_active <= 1'b0;
                    r_ready        <= 1'b1;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready     = r_ready;
    assign o_busy      = r_frame_active;
    assign o_crc_valid = r_crc_valid;
    assign o_crc       = r_crc ^ XOR_OUT;

endmodule

// File: tb/tb_serial_crc_engine.sv
// Drives four CRC flavours (XMODEM, CCITT-FALSE, KERMIT, CRC-32) from one shared
// byte stream; expected CRCs are queued per frame and checked on each strobe.
module tb_serial_crc_engine;

    localparam int unsigned DATA_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              clr;
    logic              valid;
    logic              last;
    logic [DATA_W-1:0] data;

    logic        rdy_x, busy_x, cv_x;
    logic        rdy_c, busy_c, cv_c;
    logic        rdy_k, busy_k, cv_k;
    logic        rdy_w, busy_w, cv_w;
    logic [15:0] crc_x, crc_c, crc_k;
    logic [31:0] crc_w;

    serial_crc_engine u_xm (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_data(data), .i_valid(valid),
        .i_last(last), .o_ready(rdy_x), .o_busy(busy_x), .o_crc(crc_x), .o_crc_valid(cv_x));

    serial_crc_engine #(.INIT(16'hFFFF)) u_cf (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_data(data), .i_valid(valid),
        .i_last(last), .o_ready(rdy_c), .o_busy(busy_c), .o_crc(crc_c), .o_crc_valid(cv_c));

    serial_crc_engine #(.REFLECT(1'b1)) u_km (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_data(data), .i_valid(valid),
        .i_last(last), .o_ready(rdy_k), .o_busy(busy_k), .o_crc(crc_k), .o_crc_valid(cv_k));

    serial_crc_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                        .XOR_OUT(32'hFFFFFFFF), .REFLECT(1'b1)) u_c32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr), .i_data(data), .i_valid(valid),
        .i_last(last), .o_ready(rdy_w), .o_busy(busy_w), .o_crc(crc_w), .o_crc_valid(cv_w));

    typedef struct {
        logic [15:0] x;
        logic [15:0] c;
        logic [15:0] k;
        logic [31:0] w;
    } exp_t;

    typedef struct {
        bit   single;
        bit   gaps;
        bit   press;
        exp_t e;
    } frame_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    frame_t      tbl[5];
    logic [7:0]  digits[9];
    int          n_total = 0;
    int          n_bad   = 0;
    int          meas_cyc = 0;
    bit          meas_on  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest queued frame result
    always @(negedge clk) begin
        #1;
        if (meas_on && (busy_x || (valid && rdy_x))) meas_cyc++;
        if (cv_x || cv_c || cv_k || cv_w) begin
            if (sb_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_strobe: got strobe %b%b%b%b want none",
                         cv_x, cv_c, cv_k, cv_w);
            end else begin
                sb_e = sb_q.pop_front();
                chk("strobe_align", {28'd0, cv_x, cv_c, cv_k, cv_w}, 32'hF);
                chk("crc_xmodem", {16'd0, crc_x}, {16'd0, sb_e.x});
                chk("crc_ccitt", {16'd0, crc_c}, {16'd0, sb_e.c});
                chk("crc_kermit", {16'd0, crc_k}, {16'd0, sb_e.k});
                chk("crc_32", crc_w, sb_e.w);
            end
        end
    end

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!rdy_x && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_x) chk(nm, {31'd0, rdy_x}, 32'd1);
    endtask

    task automatic send_word(input logic [7:0] d, input bit lst, input bit press);
        int n;
        wait_ready("ready_wait");
        data  = d;
        valid = 1'b1;
        last  = lst;
        @(negedge clk);
        if (press) begin
            data = 8'hFF;
            last = 1'($urandom_range(0, 1));
        end else begin
            valid = 1'b0;
        end
        n = 0;
        while (!rdy_x && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("ready_low_cycles", 32'(n), 32'(DATA_W) + 32'(lst));
        valid = 1'b0;
        last  = 1'b0;
        data  = 8'($urandom);
    endtask

    task automatic send_frame(input frame_t f);
        int nw;
        nw = f.single ? 1 : 9;
        meas_cyc = 0;
        meas_on  = 1'b1;
        for (int i = 0; i < nw; i++) begin
            if (f.gaps && i > 0) begin
                repeat ($urandom_range(1, 4)) begin
                    data = 8'($urandom);
                    @(negedge clk);
                end
            end
            if (i == nw - 1) sb_q.push_back(f.e);
            send_word(f.single ? 8'h00 : digits[i], (i == nw - 1), f.press);
        end
        meas_on = 1'b0;
        if (!f.gaps) chk("frame_cycles", 32'(meas_cyc), 32'(nw * (DATA_W + 1) + 1));
        chk("busy_after_frame", {31'd0, busy_x}, 32'd0);
        chk("crc_hold", {16'd0, crc_x}, {16'd0, f.e.x});
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_idle_init(input string nm);
        chk({nm, "_ready"}, {31'd0, rdy_x}, 32'd1);
        chk({nm, "_busy"}, {31'd0, busy_x}, 32'd0);
        chk({nm, "_crc_x"}, {16'd0, crc_x}, 32'h0000);
        chk({nm, "_crc_c"}, {16'd0, crc_c}, 32'hFFFF);
        chk({nm, "_crc_k"}, {16'd0, crc_k}, 32'h0000);
        chk({nm, "_crc_w"}, crc_w, 32'h0000_0000);
    endtask

    initial begin
        digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        tbl[0] = '{single: 1'b0, gaps: 1'b0, press: 1'b0, e: '{16'h31C3, 16'h29B1, 16'h2189, 32'hCBF43926}};
        tbl[1] = '{single: 1'b1, gaps: 1'b0, press: 1'b0, e: '{16'h0000, 16'hE1F0, 16'h0000, 32'hD202EF8D}};
        tbl[2] = '{single: 1'b0, gaps: 1'b0, press: 1'b0, e: '{16'h31C3, 16'h29B1, 16'h2189, 32'hCBF43926}};
        tbl[3] = '{single: 1'b0, gaps: 1'b1, press: 1'b1, e: '{16'h31C3, 16'h29B1, 16'h2189, 32'hCBF43926}};
        tbl[4] = '{single: 1'b1, gaps: 1'b0, press: 1'b1, e: '{16'h0000, 16'hE1F0, 16'h0000, 32'hD202EF8D}};

        rst_n = 1'b0;
        clr   = 1'b0;
        valid = 1'b1;
        last  = 1'b0;
        data  = 8'h55;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b1;
        chk_idle_init("reset");
        chk("reset_strobe", {31'd0, cv_x}, 32'd0);

        // Table frames, launched back to back
        for (int t = 0; t < 5; t++) send_frame(tbl[t]);

        // Abort with i_clear while a handshake is offered in IDLE
        for (int i = 0; i < 4; i++) send_word(digits[i], 1'b0, 1'b0);
        clr   = 1'b1;
        valid = 1'b1;
        data  = digits[4];
        @(negedge clk);
        clr   = 1'b0;
        valid = 1'b0;
        chk_idle_init("clear");
        send_frame(tbl[0]);

        // Abort with reset in the middle of a word
        for (int i = 0; i < 4; i++) send_word(digits[i], 1'b0, 1'b0);
        data  = digits[4];
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midshift_ready", {31'd0, rdy_x}, 32'd0);
        chk("midshift_busy", {31'd0, busy_x}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle_init("rst_mid");
        send_frame(tbl[0]);

        repeat (3) @(negedge clk);
        chk("final_queue", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
